register_file: RTL and testbench
================================

# register_file

Architectural register file for the 16-bit pipeline; the consumer of the write-back stage's selected `WriteData`. Holds 8 × 16-bit general registers with R0 hard-wired to zero. Provides two decode-stage read ports with same-cycle write-through bypass, a debug read port, and a committed-write counter. Registers the most recent committed write so the simulator and hazard logic can observe the last retirement.

## Interface
- `DATA_W`, 16, register and data width
- `ADDR_W`, 3, register index width
- `NUM_REGS`, 8, register count (= 2^`ADDR_W`)

- `clk` input 1: single clock, all state updates on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `RegWrite` input 1: write enable from WB stage
- `WriteReg` input `ADDR_W`: destination register index from WB stage
- `WriteData` input `DATA_W`: data selected by the write-back mux (ALU result / load data / PC+1)
- `ReadReg1` input `ADDR_W`: rs index (ID stage)
- `ReadReg2` input `ADDR_W`: rt index (ID stage)
- `ReadData1` output `DATA_W`: rs value, combinational
- `ReadData2` output `DATA_W`: rt value, combinational
- `Dbg_Addr` input `ADDR_W`: debug read index
- `Dbg_Data` output `DATA_W`: debug read value, combinational, no bypass
- `Last_Valid` output 1: a committed write has occurred since reset
- `Last_WriteReg` output `ADDR_W`: index of the most recent committed write
- `Last_WriteData` output `DATA_W`: data of the most recent committed write
- `Write_Count` output 16: number of committed writes since reset

## Operation
- Committed write: `RegWrite`=1 and `WriteReg`≠0, sampled at rising `clk`. Only a committed write changes any state.
- Committed write actions, same edge: `regs[WriteReg]` ← `WriteData`; `Last_Valid` ← 1; `Last_WriteReg` ← `WriteReg`; `Last_WriteData` ← `WriteData`; `Write_Count` ← `Write_Count`+1.
- Write to R0 (`RegWrite`=1, `WriteReg`=0): fully ignored. R0 unchanged, counter and `Last_*` unchanged.
- `RegWrite`=0: no state change regardless of `WriteReg`/`WriteData`.
- Read port n (n=1,2):
  - index 0 → 0.
  - else if `RegWrite`=1 and `WriteReg`=`ReadRegn` → `WriteData` (write-through bypass, so write-first semantics within one cycle).
  - else → `regs[ReadRegn]`.
- Both read ports are independent. Both may hit the bypass in the same cycle.
- Debug port: index 0 → 0, else `regs[Dbg_Addr]`. No bypass, so it shows only the pre-edge stored value.
- `Write_Count` wraps 0xFFFF → 0x0000 modulo 2^16, with no saturation.
- No stall or flush inputs: the WB stage deasserts `RegWrite` for bubbles and squashed instructions.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate):
  - all registers = 0x0000; `Last_Valid`=0; `Last_WriteReg`=0; `Last_WriteData`=0x0000; `Write_Count`=0.
  - read outputs therefore show 0, except bypass (combinational) still applies from inputs.
- Reset deassertion: first committed write is taken on the first rising edge with `rst_n`=1.
- Reset asserted mid-operation: a write presented in the same cycle is lost. Every register returns to 0.
- Write latency: stored value is visible on the non-bypass path and `Dbg_Data` one cycle after the edge. `ReadDatan` shows it in the same cycle through the bypass.
- Read latency: 0 cycles, purely combinational from `ReadRegn`/`RegWrite`/`WriteReg`/`WriteData`/state.
- Consecutive writes to the same register on back-to-back edges: the last write wins, and `Write_Count` increments by 2.

## Test plan
- Reset then read: pulse `rst_n` low mid-cycle, write R3=0x1234 with `rst_n` low → after release `Dbg_Addr`=3 gives 0x0000, `Write_Count`=0, `Last_Valid`=0.
- Write then read: write R5=0xBEEF, next cycle `ReadReg1`=5, `RegWrite`=0 → `ReadData1`=0xBEEF; `Last_WriteReg`=5, `Last_WriteData`=0xBEEF, `Write_Count`=1.
- Bypass: R2 holds 0x0001, present `RegWrite`=1, `WriteReg`=2, `WriteData`=0x00AA, `ReadReg1`=`ReadReg2`=2 → both read ports =0x00AA in the same cycle, `Dbg_Addr`=2 gives 0x0001 until the edge.
- R0 protection: `RegWrite`=1, `WriteReg`=0, `WriteData`=0xFFFF → `ReadData1`(idx 0)=0 both before and after the edge, `Write_Count` and `Last_*` unchanged.
- Disabled write: `RegWrite`=0, `WriteReg`=4, `WriteData`=0x5555 → R4 unchanged, no bypass, counter unchanged.
- Counter wrap: 65536 committed writes to R1 (incrementing data) → `Write_Count`=0x0000, R1 = last data, `Last_Valid`=1.

Source files
------------

// File: rtl/register_file_if.sv
// Register-file access bundle: write-back write port, two decode read ports,
// debug read port and last-retirement observation signals.
interface register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  // Write-back stage write port
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  // Decode stage read ports
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  // Debug read port
  logic [ADDR_W-1:0] Dbg_Addr;
  logic [DATA_W-1:0] Dbg_Data;
  // Last committed write observation
  logic              Last_Valid;
  logic [ADDR_W-1:0] Last_WriteReg;
  logic [DATA_W-1:0] Last_WriteData;
  logic [15:0]       Write_Count;

  // Pipeline side: drives indices and write data, consumes read data.
  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, Dbg_Addr,
    input  ReadData1, ReadData2, Dbg_Data,
           Last_Valid, Last_WriteReg, Last_WriteData, Write_Count
  );

  // Register file side.
  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, Dbg_Addr,
    output ReadData1, ReadData2, Dbg_Data,
           Last_Valid, Last_WriteReg, Last_WriteData, Write_Count
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file: 8 x 16-bit, R0 reads as zero and ignores
// writes. Two decode read ports with write-through bypass, a debug port
// without bypass, and a record of the most recent committed write.
module register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] dbg_data;
  logic              last_valid;
  logic [ADDR_W-1:0] last_write_reg;
  logic [DATA_W-1:0] last_write_data;
  logic [15:0]       write_count;

  // A write to R0 is not a commit: it changes no state at all.
  assign commit = bus.RegWrite && (bus.WriteReg != '0);

  // Register array update; the whole array clears on reset.
  // NOTE: this array must be built from resettable flops, not a RAM macro,
  // because every register has to read back zero immediately after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Last-retirement record and wrapping commit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_valid      <= 1'b0;
      last_write_reg  <= '0;
      last_write_data <= '0;
      write_count     <= '0;
    end else if (commit) begin
      last_valid      <= 1'b1;
      last_write_reg  <= bus.WriteReg;
      last_write_data <= bus.WriteData;
      write_count     <= write_count + 16'd1;
    end
  end

  // Decode read ports: R0 is zero, a same-cycle write to the index forwards.
  // NOTE: each output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (bus.ReadReg1 != '0) begin
      if (bus.RegWrite && (bus.WriteReg == bus.ReadReg1)) begin
        read_data1 = bus.WriteData;
      end else begin
        read_data1 = regs[bus.ReadReg1];
      end
    end
    if (bus.ReadReg2 != '0) begin
      if (bus.RegWrite && (bus.WriteReg == bus.ReadReg2)) begin
        read_data2 = bus.WriteData;
      end else begin
        read_data2 = regs[bus.ReadReg2];
      end
    end
  end

  // Debug port shows only the stored value, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (bus.Dbg_Addr != '0) begin
      dbg_data = regs[bus.Dbg_Addr];
    end
  end

  assign bus.ReadData1      = read_data1;
  assign bus.ReadData2      = read_data2;
  assign bus.Dbg_Data       = dbg_data;
  assign bus.Last_Valid     = last_valid;
  assign bus.Last_WriteReg  = last_write_reg;
  assign bus.Last_WriteData = last_write_data;
  assign bus.Write_Count    = write_count;

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file with a behavioural model
// (plain array plus counters) checked against the outputs every cycle.
module tb_register_file;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   check_en;

  register_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [15:0] model_regs [8];
  bit          model_valid;
  logic [2:0]  model_last_reg;
  logic [15:0] model_last_data;
  int          model_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] idx);
    if (idx == 3'd0) return 16'h0000;
    if (bus.RegWrite && bus.WriteReg == idx) return bus.WriteData;
    return model_regs[idx];
  endfunction

  function automatic logic [15:0] model_dbg(input logic [2:0] idx);
    return (idx == 3'd0) ? 16'h0000 : model_regs[idx];
  endfunction

  // Model update: reset clears everything at once; a commit is a write
  // enable with a nonzero destination seen at a rising edge out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
      model_valid     = 1'b0;
      model_last_reg  = 3'd0;
      model_last_data = 16'h0000;
      model_count     = 0;
    end else if (bus.RegWrite && bus.WriteReg != 3'd0) begin
      model_regs[bus.WriteReg] = bus.WriteData;
      model_valid     = 1'b1;
      model_last_reg  = bus.WriteReg;
      model_last_data = bus.WriteData;
      model_count     = (model_count + 1) % 65536;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("rd1",        bus.ReadData1,      model_read(bus.ReadReg1));
      check("rd2",        bus.ReadData2,      model_read(bus.ReadReg2));
      check("dbg",        bus.Dbg_Data,       model_dbg(bus.Dbg_Addr));
      check("last_valid", bus.Last_Valid,     model_valid);
      check("last_reg",   bus.Last_WriteReg,  model_last_reg);
      check("last_data",  bus.Last_WriteData, model_last_data);
      check("count",      bus.Write_Count,    model_count[15:0]);
    end
  end

  // Present one cycle of inputs just after a rising edge.
  task automatic step(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                      input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] dbg);
    @(posedge clk);
    #1;
    bus.RegWrite  = we;
    bus.WriteReg  = wr;
    bus.WriteData = wd;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
    bus.Dbg_Addr  = dbg;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_valid = 1'b0; model_last_reg = 3'd0; model_last_data = 16'h0000; model_count = 0;
    bus.RegWrite = 1'b0; bus.WriteReg = 3'd0; bus.WriteData = 16'h0000;
    bus.ReadReg1 = 3'd0; bus.ReadReg2 = 3'd0; bus.Dbg_Addr = 3'd0;
    #23 rst_n = 1'b1;
    check_en = 1'b1;

    // Reset mid-operation: stored R3 clears, the write presented in reset is lost.
    step(1'b1, 3'd3, 16'h7777, 3'd0, 3'd0, 3'd3);
    step(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 3'd3);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("lit_reset_dbg_in_reset", bus.Dbg_Data, 16'h0000);
    step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 3'd3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("lit_reset_dbg3",  bus.Dbg_Data,    16'h0000);
    check("lit_reset_count", bus.Write_Count, 16'h0000);
    check("lit_reset_valid", bus.Last_Valid,  1'b0);

    // Write then read.
    step(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd0, 3'd5);
    @(negedge clk);
    check("lit_wr_bypass", bus.ReadData1, 16'hBEEF);
    check("lit_wr_dbg_pre", bus.Dbg_Data, 16'h0000);
    step(1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 3'd5);
    @(negedge clk);
    check("lit_rd5",        bus.ReadData1,      16'hBEEF);
    check("lit_last_reg",   bus.Last_WriteReg,  3'd5);
    check("lit_last_data",  bus.Last_WriteData, 16'hBEEF);
    check("lit_count1",     bus.Write_Count,    16'd1);

    // Dual-port bypass while debug still sees the old value.
    step(1'b1, 3'd2, 16'h0001, 3'd0, 3'd0, 3'd2);
    step(1'b1, 3'd2, 16'h00AA, 3'd2, 3'd2, 3'd2);
    @(negedge clk);
    check("lit_byp_rd1", bus.ReadData1, 16'h00AA);
    check("lit_byp_rd2", bus.ReadData2, 16'h00AA);
    check("lit_byp_dbg", bus.Dbg_Data,  16'h0001);

    // R0 protection.
    step(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    check("lit_r0_pre", bus.ReadData1, 16'h0000);
    step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd2, 3'd0);
    @(negedge clk);
    check("lit_r0_post",   bus.ReadData1,      16'h0000);
    check("lit_r0_count",  bus.Write_Count,    16'd3);
    check("lit_r0_lreg",   bus.Last_WriteReg,  3'd2);
    check("lit_r0_ldata",  bus.Last_WriteData, 16'h00AA);

    // Disabled write: no bypass, no state change.
    step(1'b1, 3'd4, 16'h1111, 3'd0, 3'd0, 3'd0);
    step(1'b0, 3'd4, 16'h5555, 3'd4, 3'd4, 3'd4);
    @(negedge clk);
    check("lit_dis_rd1", bus.ReadData1, 16'h1111);
    step(1'b0, 3'd0, 16'h0000, 3'd4, 3'd0, 3'd4);
    @(negedge clk);
    check("lit_dis_dbg",   bus.Dbg_Data,    16'h1111);
    check("lit_dis_count", bus.Write_Count, 16'd4);

    // Randomised traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wr;
      wr = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, wr, 16'($urandom),
           ($urandom_range(0, 2) == 0) ? wr : 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0) ? wr : 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end

    // Counter wrap: reset, then 65536 commits to R1 with data 0..0xFFFF.
    step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 3'd1, 16'(i), 3'd1, 3'd2, 3'd1);
      if (i == 65535) begin
        @(negedge clk);
        check("lit_count_pre_wrap", bus.Write_Count, 16'hFFFF);
      end
    end
    step(1'b0, 3'd0, 16'h0000, 3'd1, 3'd0, 3'd1);
    @(negedge clk);
    check("lit_wrap_count",  bus.Write_Count,    16'h0000);
    check("lit_wrap_dbg",    bus.Dbg_Data,       16'hFFFF);
    check("lit_wrap_rd1",    bus.ReadData1,      16'hFFFF);
    check("lit_wrap_valid",  bus.Last_Valid,     1'b1);
    check("lit_wrap_ldata",  bus.Last_WriteData, 16'hFFFF);
    check("lit_model_count", model_count,        32'd0);

    @(posedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
